// File: rtl/launch_countdown_if.sv
// Control/status bundle between the countdown sequencer and its button/display logic.
// The hold signal exists only when COUNTDOWN_HOLD_EN is defined.
interface launch_countdown_if;
  logic       tick_1hz;
  logic       start;
  logic       abort;
`ifdef COUNTDOWN_HOLD_EN
  logic       hold;
`endif
  logic [2:0] state;
  logic [6:0] seconds_left;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       launch;
  logic       launch_pulse;

  modport master (
    output tick_1hz, start, abort,
`ifdef COUNTDOWN_HOLD_EN
    output hold,
`endif
    input  state, seconds_left, bcd_tens, bcd_ones, launch, launch_pulse
  );

  modport slave (
    input  tick_1hz, start, abort,
`ifdef COUNTDOWN_HOLD_EN
    input  hold,
`endif
    output state, seconds_left, bcd_tens, bcd_ones, launch, launch_pulse
  );
endinterface

// File: rtl/launch_countdown.sv
// Launch countdown sequencer: IDLE -> COUNTING -> LAUNCH with abort, plus an
// optional hold/resume feature enabled by defining COUNTDOWN_HOLD_EN.
module launch_countdown #(
  parameter int COUNT_START    = 10,
  parameter int LAUNCH_SECONDS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  launch_countdown_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COUNTING = 3'd1,
    HOLD     = 3'd2,
    LAUNCH   = 3'd3,
    ABORTED  = 3'd4
  } state_t;

  localparam logic [6:0] START_VAL = 7'(COUNT_START);
  localparam logic [3:0] LAST_TICK = 4'(LAUNCH_SECONDS - 1);

  state_t     r_state;
  logic [6:0] r_secs;
  logic [3:0] r_lcnt;
  logic       r_launch;
  logic       r_launchPulse;
  logic       w_hold;
  logic [3:0] w_tens;
  logic [3:0] w_ones;

`ifdef COUNTDOWN_HOLD_EN
  assign w_hold = bus.hold;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_secs        <= START_VAL;
      r_lcnt        <= 4'd0;
      r_launch      <= 1'b0;
      r_launchPulse <= 1'b0;
    end else begin
      r_launchPulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) r_state <= COUNTING;
        end
        COUNTING: begin
          // Abort beats hold, and hold swallows a coincident tick.
          if (bus.abort) begin
            r_state <= ABORTED;
          end else if (w_hold) begin
            r_state <= HOLD;
          end else if (bus.tick_1hz) begin
            if (r_secs <= 7'd1) begin
              r_secs        <= 7'd0;
              r_state       <= LAUNCH;
              r_launch      <= 1'b1;
              r_launchPulse <= 1'b1;
              r_lcnt        <= 4'd0;
            end else begin
              r_secs <= r_secs - 7'd1;
            end
          end
        end
        HOLD: begin
          if (bus.abort) r_state <= ABORTED;
          else if (w_hold) r_state <= COUNTING;
        end
        LAUNCH: begin
          if (bus.tick_1hz) begin
            if (r_lcnt == LAST_TICK) begin
              r_state  <= IDLE;
              r_secs   <= START_VAL;
              r_launch <= 1'b0;
              r_lcnt   <= 4'd0;
            end else begin
              r_lcnt <= r_lcnt + 4'd1;
            end
          end
        end
        ABORTED: begin
          if (bus.start) begin
            r_state <= IDLE;
            r_secs  <= START_VAL;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_secs   <= START_VAL;
          r_launch <= 1'b0;
          r_lcnt   <= 4'd0;
        end
      endcase
    end
  end

  // Binary-to-BCD by threshold compare; the count never exceeds 99.
  always_comb begin
    w_tens = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (r_secs >= 7'(k * 10)) w_tens = 4'(k);
    end
    w_ones = 4'(r_secs - 7'(7'(w_tens) * 7'd10));
  end

  assign bus.state        = r_state;
  assign bus.seconds_left = r_secs;
  assign bus.bcd_tens     = w_tens;
  assign bus.bcd_ones     = w_ones;
  assign bus.launch       = r_launch;
  assign bus.launch_pulse = r_launchPulse;

endmodule

// File: tb/tb_launch_countdown.sv
// Directed bench for launch_countdown: one default instance and one with COUNT_START=25
// share the same stimulus; hold steps run only when COUNTDOWN_HOLD_EN is defined.
module tb_launch_countdown;

  logic clk;
  logic rst_n;
  logic tick;
  logic startIn;
  logic abortIn;
  int   checks;
  int   errors;

  launch_countdown_if busA ();
  launch_countdown_if busB ();

  assign busA.tick_1hz = tick;
  assign busA.start    = startIn;
  assign busA.abort    = abortIn;
  assign busB.tick_1hz = tick;
  assign busB.start    = startIn;
  assign busB.abort    = abortIn;

`ifdef COUNTDOWN_HOLD_EN
  logic holdIn;
  assign busA.hold = holdIn;
  assign busB.hold = holdIn;
`endif

  launch_countdown dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  launch_countdown #(.COUNT_START(25), .LAUNCH_SECONDS(3)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: drive after the falling edge, release 1 ns after the rising edge.
  task automatic applyStimulus(input logic t, input logic s, input logic a);
    @(negedge clk);
    tick    = t;
    startIn = s;
    abortIn = a;
    @(posedge clk);
    #1;
    tick    = 1'b0;
    startIn = 1'b0;
    abortIn = 1'b0;
  endtask

`ifdef COUNTDOWN_HOLD_EN
  task automatic applyHold(input logic t);
    @(negedge clk);
    tick   = t;
    holdIn = 1'b1;
    @(posedge clk);
    #1;
    tick   = 1'b0;
    holdIn = 1'b0;
  endtask
`endif

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    tick    = 1'b0;
    startIn = 1'b0;
    abortIn = 1'b0;
`ifdef COUNTDOWN_HOLD_EN
    holdIn  = 1'b0;
`endif
    rst_n   = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_state",  8'(busA.state), 8'd0);
    checkOutput("rst_secs",   8'(busA.seconds_left), 8'd10);
    checkOutput("rst_launch", 8'(busA.launch), 8'd0);
    checkOutput("rst_pulse",  8'(busA.launch_pulse), 8'd0);
    checkOutput("rst_secsB",  8'(busB.seconds_left), 8'd25);
    checkOutput("idle_tens",  8'(busA.bcd_tens), 8'd1);
    checkOutput("idle_ones",  8'(busA.bcd_ones), 8'd0);
    rst_n = 1'b1;

    // Full countdown to launch with ignored abort/start inside LAUNCH.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("start_state", 8'(busA.state), 8'd1);
    checkOutput("start_secs",  8'(busA.seconds_left), 8'd10);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("cnt_secs",  8'(busA.seconds_left), 8'(10 - i));
      checkOutput("cnt_tens",  8'(busA.bcd_tens), 8'((10 - i) / 10));
      checkOutput("cnt_ones",  8'(busA.bcd_ones), 8'((10 - i) % 10));
      checkOutput("cnt_state", 8'(busA.state), (i == 10) ? 8'd3 : 8'd1);
      checkOutput("cnt_pulse", 8'(busA.launch_pulse), (i == 10) ? 8'd1 : 8'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pulse_once",   8'(busA.launch_pulse), 8'd0);
    checkOutput("launch_high",  8'(busA.launch), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("launch_abort", 8'(busA.state), 8'd3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("launch_start", 8'(busA.state), 8'd3);
    checkOutput("launch_secs",  8'(busA.seconds_left), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("launch_t2",    8'(busA.launch), 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("launch_end_state",  8'(busA.state), 8'd0);
    checkOutput("launch_end_launch", 8'(busA.launch), 8'd0);
    checkOutput("launch_end_secs",   8'(busA.seconds_left), 8'd10);

    // Abort coincident with the fifth tick.
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre_abort_secs", 8'(busA.seconds_left), 8'd6);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("abort_state", 8'(busA.state), 8'd4);
    checkOutput("abort_secs",  8'(busA.seconds_left), 8'd6);
    checkOutput("abort_tens",  8'(busA.bcd_tens), 8'd0);
    checkOutput("abort_ones",  8'(busA.bcd_ones), 8'd6);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("aborted_frozen", 8'(busA.seconds_left), 8'd6);
    checkOutput("aborted_stay",   8'(busA.state), 8'd4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rearm_state", 8'(busA.state), 8'd0);
    checkOutput("rearm_secs",  8'(busA.seconds_left), 8'd10);

    // Start with a coincident tick: that tick is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("coinc_state", 8'(busA.state), 8'd1);
    checkOutput("coinc_secs",  8'(busA.seconds_left), 8'd10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("coinc_wait",  8'(busA.seconds_left), 8'd10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("coinc_next",  8'(busA.seconds_left), 8'd9);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cnt_start_ign", 8'(busA.seconds_left), 8'd9);
    checkOutput("cnt_start_st",  8'(busA.state), 8'd1);

    // Reset mid-count, then start+abort together in IDLE starts both instances.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    checkOutput("midrst_secs", 8'(busA.seconds_left), 8'd10);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("sa_stateA", 8'(busA.state), 8'd1);
    checkOutput("sa_stateB", 8'(busB.state), 8'd1);
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("b13_secs",   8'(busB.seconds_left), 8'd12);
    checkOutput("b13_tens",   8'(busB.bcd_tens), 8'd1);
    checkOutput("b13_ones",   8'(busB.bcd_ones), 8'd2);
    checkOutput("a13_state",  8'(busA.state), 8'd0);
    checkOutput("a13_secs",   8'(busA.seconds_left), 8'd10);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    checkOutput("b_rst_state",  8'(busB.state), 8'd0);
    checkOutput("b_rst_secs",   8'(busB.seconds_left), 8'd25);
    checkOutput("b_rst_launch", 8'(busB.launch), 8'd0);

    // Reset in the middle of LAUNCH.
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ml_launch", 8'(busA.launch), 8'd1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    checkOutput("ml_rst_launch", 8'(busA.launch), 8'd0);
    checkOutput("ml_rst_state",  8'(busA.state), 8'd0);
    checkOutput("ml_rst_secs",   8'(busA.seconds_left), 8'd10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("resume_state",  8'(busA.state), 8'd1);

`ifdef COUNTDOWN_HOLD_EN
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyHold(1'b0);
    checkOutput("hold_state", 8'(busA.state), 8'd2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hold_secs",  8'(busA.seconds_left), 8'd7);
    applyHold(1'b0);
    checkOutput("resume_st",  8'(busA.state), 8'd1);
    checkOutput("resume_secs", 8'(busA.seconds_left), 8'd7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("after_hold", 8'(busA.seconds_left), 8'd6);
    applyHold(1'b1);
    checkOutput("hold_tick_st",   8'(busA.state), 8'd2);
    checkOutput("hold_tick_secs", 8'(busA.seconds_left), 8'd6);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("hold_abort", 8'(busA.state), 8'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/launch_countdown.md
LAUNCH_COUNTDOWN -- requirements
Module: launch_countdown

Interface
REQ-001 SHALL have parameter COUNT_START, default 10, countdown start value in seconds (legal 1..99).
REQ-002 SHALL have parameter LAUNCH_SECONDS, default 3, number of 1 Hz ticks the launch output stays asserted (legal 1..15).
REQ-003 SHALL have port clk  input  1  12 MHz system clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port tick_1hz  input  1  one-cycle pulse once per second from the 1 Hz divider.
REQ-006 SHALL have port start  input  1  one-cycle synchronous pulse from the debounced start button.
REQ-007 SHALL have port abort  input  1  one-cycle synchronous pulse from the debounced abort button.
REQ-008 SHALL have port hold  input  1  one-cycle pulse that toggles hold/resume (present only with COUNTDOWN_HOLD_EN).
REQ-009 SHALL have port state  output  3  FSM state: IDLE=0, COUNTING=1, HOLD=2, LAUNCH=3, ABORTED=4.
REQ-010 SHALL have port seconds_left  output  7  registered binary seconds remaining.
REQ-011 SHALL have port bcd_tens  output  4  tens digit of seconds_left, combinational from the register.
REQ-012 SHALL have port bcd_ones  output  4  ones digit of seconds_left, combinational from the register.
REQ-013 SHALL have port launch  output  1  high for the whole LAUNCH state.
REQ-014 SHALL have port launch_pulse  output  1  one-cycle pulse on the clock edge that enters LAUNCH.

Function
REQ-015 In IDLE, seconds_left SHALL equal COUNT_START; start SHALL move to COUNTING on the next edge without changing seconds_left.
REQ-016 A tick_1hz coincident with the start pulse SHALL be ignored; the first decrement SHALL occur on the next tick_1hz.
REQ-017 In COUNTING, each tick_1hz SHALL decrement seconds_left by 1 on the same edge.
REQ-018 A tick_1hz in COUNTING with seconds_left==1 SHALL set seconds_left to 0, enter LAUNCH, and assert launch_pulse for exactly that one cycle.
REQ-019 In LAUNCH, an internal 4-bit counter SHALL count tick_1hz; on the LAUNCH_SECONDS-th tick the FSM SHALL return to IDLE and reload seconds_left to COUNT_START.
REQ-020 In LAUNCH, start and abort SHALL be ignored; launch is irreversible.
REQ-021 abort in COUNTING or HOLD SHALL enter ABORTED on the next edge with seconds_left frozen; abort SHALL take priority over a coincident tick_1hz or hold.
REQ-022 abort in IDLE or ABORTED SHALL be ignored; start+abort together in IDLE SHALL start the countdown.
REQ-023 In ABORTED, start SHALL reload seconds_left to COUNT_START and enter IDLE; a second start is needed to begin counting.
REQ-024 start in COUNTING or HOLD SHALL be ignored.
REQ-025 seconds_left SHALL never wrap below 0 or exceed COUNT_START.
REQ-026 bcd_tens/bcd_ones SHALL satisfy 10*bcd_tens+bcd_ones==seconds_left for every value 0..99, with zero added latency.

Reset
REQ-027 With rst_n low at a clock edge: state=IDLE, seconds_left=COUNT_START, launch=0, launch_pulse=0, launch counter=0, regardless of current state.
REQ-028 Reset SHALL override all inputs, including mid-count and mid-launch; operation resumes on the first edge with rst_n high.

Configuration
REQ-029 Macro COUNTDOWN_HOLD_EN defined: hold port exists; hold in COUNTING enters HOLD, hold in HOLD returns to COUNTING; tick_1hz in HOLD is discarded; a hold coincident with tick_1hz in COUNTING takes effect and that tick is discarded; hold in other states is ignored.
REQ-030 Macro COUNTDOWN_HOLD_EN undefined: hold port absent, HOLD state unreachable, state encoding unchanged.

Verification
REQ-031 Reset, start, 10 ticks -> seconds_left 10,9,...,1,0; launch_pulse one cycle at tick 10; launch high 3 ticks; then IDLE, seconds_left=10.
REQ-032 start, 4 ticks, abort coincident with tick 5 -> ABORTED, seconds_left=6, bcd_tens=0, bcd_ones=6; start -> IDLE, seconds_left=10.
REQ-033 start with coincident tick -> seconds_left stays 10 until next tick, then 9.
REQ-034 COUNT_START=25: start, 13 ticks -> seconds_left=12, bcd_tens=1, bcd_ones=2; rst_n low one edge -> IDLE, seconds_left=25, launch=0.
REQ-035 During LAUNCH: abort and start pulses -> no effect; rst_n low mid-launch -> launch=0, IDLE next edge.
REQ-036 COUNTDOWN_HOLD_EN: start, 3 ticks, hold, 5 ticks, hold, 1 tick -> seconds_left 7 held through HOLD, then 6.
